// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and sizing helper for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {REQ_IF, REQ_D} req_t;

    function automatic int cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data load/store,
// round-robin on contention, with a registered address/data phase and a one-cycle done pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_raddress,
    output logic [ADDR_W-1:0] mem_waddress,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              busy
);

    localparam int CNT_W = cnt_width(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end

    state_t            state_q, state_d;
    req_t              owner_q, owner_d;
    req_t              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              idle;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            owner_q    <= REQ_IF;
            last_q     <= REQ_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (if_gnt || d_gnt) begin
                    state_d = ACCESS;
                    owner_d = d_gnt ? REQ_D : REQ_IF;
                    last_d  = owner_d;
                    addr_d  = d_gnt ? d_addr : if_addr;
                    wdata_d = d_gnt ? d_wdata : wdata_q;
                    we_d    = d_gnt && d_we;
                    cnt_d   = CNT_INIT;
                end
            end
            ACCESS: begin
                // writes take a single cycle; reads wait for the counter to expire
                if (we_q || cnt_q == '0) begin
                    state_d    = DONE;
                    d_rdata_d  = (!we_q && owner_q == REQ_D) ? mem_dataout : d_rdata_q;
                    if_rdata_d = (!we_q && owner_q == REQ_IF) ? mem_dataout : if_rdata_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idle         = state_q == IDLE && !RESET;
        d_gnt        = idle && d_req && (!if_req || last_q == REQ_IF);
        if_gnt       = idle && if_req && !d_gnt;
        if_done      = state_q == DONE && owner_q == REQ_IF;
        d_done       = state_q == DONE && owner_q == REQ_D;
        mem_wr       = state_q == ACCESS && we_q;
        busy         = state_q != IDLE;
        mem_raddress = addr_q;
        mem_waddress = addr_q;
        mem_datain   = wdata_q;
        if_rdata     = if_rdata_q;
        d_rdata      = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a scoreboard queue; a negedge monitor
// checks done pulses, read data, write strobes and addresses against queued expectations.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    typedef struct {
        bit          own_d;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          gcyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_gnt, if_done;
    logic [63:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic        d_gnt, d_done;
    logic [63:0] d_rdata;
    logic [63:0] mem_raddress, mem_waddress, mem_datain, mem_dataout;
    logic        mem_wr, busy;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [63:0] apipe = '0;
    logic [63:0] exp_if = '0;
    logic [63:0] exp_d = '0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT)) dut (
        .CLK(CLK), .RESET(RESET),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_raddress(mem_raddress), .mem_waddress(mem_waddress), .mem_datain(mem_datain),
        .mem_wr(mem_wr), .mem_dataout(mem_dataout), .busy(busy)
    );

    function automatic logic [63:0] memf(input logic [63:0] a);
        return (a == 64'h40) ? 64'hDEADBEEF_CAFEF00D : {32'h5A5A0000 ^ a[31:0], ~a[31:0]};
    endfunction

    // memory: data for the address seen last cycle, so an early capture reads stale data
    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        apipe <= mem_raddress;
    end
    assign mem_dataout = memf(apipe);

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge CLK) begin
        if (busy && sb.size() != 0) begin
            chk("mem_raddress", mem_raddress, sb[0].addr);
            chk("mem_waddress", mem_waddress, sb[0].addr);
        end
        if (if_gnt || d_gnt)
            chk("gnt_while_busy", 64'(busy), 64'd0);
        if (mem_wr) begin
            if (sb.size() == 0 || !sb[0].we) begin
                chk("mem_wr_unexpected", 64'd1, 64'd0);
            end else begin
                chk("mem_wr_cycle", 64'(cyc), 64'(sb[0].gcyc + 1));
                chk("mem_datain", mem_datain, sb[0].wdata);
            end
        end
        if (if_done || d_done) begin
            if (sb.size() == 0) begin
                chk("done_without_access", {62'b0, if_done, d_done}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_owner", {62'b0, if_done, d_done}, mon_e.own_d ? 64'd1 : 64'd2);
                chk("done_cycle", 64'(cyc), 64'(mon_e.gcyc + (mon_e.we ? 2 : LAT + 1)));
                if (!mon_e.we) begin
                    if (mon_e.own_d) exp_d = memf(mon_e.addr);
                    else exp_if = memf(mon_e.addr);
                end
                chk("if_rdata", if_rdata, exp_if);
                chk("d_rdata", d_rdata, exp_d);
            end
        end
    end

    task automatic wait_gnt(input bit own_d, output int gc);
        gc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (own_d ? d_gnt : if_gnt) begin
                gc = cyc;
                break;
            end
        end
        if (gc < 0) chk("gnt_timeout", 64'd0, 64'd1);
    endtask

    task automatic access(input bit own_d, input bit we, input logic [63:0] addr, input logic [63:0] wdata);
        int gc;
        @(posedge CLK); #1;
        if (own_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        wait_gnt(own_d, gc);
        if (gc >= 0) sb.push_back('{own_d, we, addr, wdata, gc});
        @(posedge CLK); #1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '1; d_addr = '1; d_wdata = '1;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge CLK);
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET = 1'b1;
        sb.delete();
        exp_if = '0;
        exp_d  = '0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        int g1, g2, prev;
        bit own;
        // reset state, with requests held to confirm no grant leaks out during reset
        if_req = 1'b1; d_req = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_ctrl", {58'b0, if_gnt, d_gnt, if_done, d_done, mem_wr, busy}, 64'd0);
        chk("rst_raddr", mem_raddress, 64'd0);
        chk("rst_waddr", mem_waddress, 64'd0);
        chk("rst_datain", mem_datain, 64'd0);
        chk("rst_if_rdata", if_rdata, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        if_req = 1'b0; d_req = 1'b0;
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        chk("idle_ctrl", {58'b0, if_gnt, d_gnt, if_done, d_done, mem_wr, busy}, 64'd0);

        // fetch read
        access(1'b0, 1'b0, 64'h40, 64'h0);
        drain();
        repeat (3) @(negedge CLK);
        chk("if_rdata_hold", if_rdata, 64'hDEADBEEF_CAFEF00D);
        chk("d_rdata_untouched", d_rdata, 64'd0);
        chk("raddr_hold_idle", mem_raddress, 64'h40);

        // data write, then a data read of the same address
        access(1'b1, 1'b1, 64'h100, 64'h1234);
        drain();
        chk("d_rdata_after_write", d_rdata, 64'd0);
        chk("waddr_hold_idle", mem_waddress, 64'h100);
        access(1'b1, 1'b0, 64'h100, 64'h0);
        drain();
        chk("if_rdata_after_d", if_rdata, 64'hDEADBEEF_CAFEF00D);

        // both requesters held: D, IF, D, IF spaced LAT+2 cycles
        pulse_reset();
        @(posedge CLK); #1;
        if_req = 1'b1; if_addr = 64'h200;
        d_req = 1'b1; d_addr = 64'h300; d_we = 1'b0;
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(k % 2 == 0, g1);
            if (g1 < 0) break;
            own = (k % 2 == 0);
            chk("rr_single_gnt", {62'b0, if_gnt, d_gnt}, own ? 64'd1 : 64'd2);
            if (prev >= 0) chk("rr_spacing", 64'(g1 - prev), 64'(LAT + 2));
            sb.push_back('{own, 1'b0, own ? 64'h300 : 64'h200, 64'h0, g1});
            prev = g1;
        end
        @(posedge CLK); #1;
        if_req = 1'b0; d_req = 1'b0;
        drain();

        // reset in the middle of a fetch read
        @(posedge CLK); #1;
        if_req = 1'b1; if_addr = 64'h40;
        wait_gnt(1'b0, g1);
        @(posedge CLK); #1;
        if_req = 1'b0;
        RESET = 1'b1;
        exp_if = '0;
        exp_d  = '0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_if_rdata", if_rdata, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (6) @(negedge CLK);
        chk("midrst_no_done_rdata", if_rdata, 64'd0);
        access(1'b0, 1'b0, 64'h80, 64'h0);
        drain();

        // fetch request held through done; the re-grant uses the new address
        @(posedge CLK); #1;
        if_req = 1'b1; if_addr = 64'h40;
        wait_gnt(1'b0, g1);
        if (g1 >= 0) sb.push_back('{1'b0, 1'b0, 64'h40, 64'h0, g1});
        @(posedge CLK); #1;
        if_addr = 64'h48;
        wait_gnt(1'b0, g2);
        if (g2 >= 0) sb.push_back('{1'b0, 1'b0, 64'h48, 64'h0, g2});
        chk("regrant_cycle", 64'(g2 - g1), 64'(LAT + 2));
        @(posedge CLK); #1;
        if_req = 1'b0;
        drain();
        repeat (2) @(negedge CLK);
        chk("final_if_rdata", if_rdata, memf(64'h48));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single memory port between two requesters: instruction fetch (read-only, driven by the control unit) and data load/store.
- Serialises accesses and registers the address and write data at grant.
- Waits out the memory read latency, captures the read data and returns a one-cycle done pulse to the owning requester.
- Sits between the control unit / datapath and the 64-bit memory.

Parameters:
ADDR_W, 64, address width.
DATA_W, 64, data width.
MEM_LAT, 2, cycles from address presented to valid mem_dataout; legal range is MEM_LAT >= 1 (elaboration error otherwise).

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  asynchronous, active-high reset.
if_req  in  1  fetch read request (level).
if_addr  in  ADDR_W  fetch address.
if_gnt  out  1  fetch request accepted this cycle.
if_done  out  1  one-cycle pulse: fetch read complete.
if_rdata  out  DATA_W  fetch read data; valid from if_done, held until the next fetch completion.
d_req  in  1  data request (level).
d_we  in  1  1 = write, 0 = read.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  data write value.
d_gnt  out  1  data request accepted this cycle.
d_done  out  1  one-cycle pulse: data access complete.
d_rdata  out  DATA_W  data read value; valid from d_done, held until the next data read completion.
mem_raddress  out  ADDR_W  memory read address.
mem_waddress  out  ADDR_W  memory write address.
mem_datain  out  DATA_W  memory write data.
mem_wr  out  1  memory write strobe.
mem_dataout  in  DATA_W  memory read data.
busy  out  1  access in progress (state != IDLE).

Behaviour:
- States: IDLE, ACCESS, DONE. Owner register: IF or D. last_grant register.
- Reset (async, any state): state = IDLE, last_grant = IF, and all of the following clear to 0: every output, the address/data registers, the counter and both rdata registers. No done pulse may follow a reset, including a reset mid-access.
- IDLE arbitration, combinational gnt:
  - Only one req high: grant it.
  - Both high: grant the requester that is not last_grant. Data therefore wins first after reset.
  - Exactly one gnt per accepted access; gnt is never asserted outside IDLE.
- Grant edge:
  - Latch the address into addr_q. Latch d_wdata/d_we only if the owner is D; fetch is always a read.
  - Set owner, set last_grant = owner, state goes to ACCESS.
- mem_raddress = mem_waddress = addr_q and mem_datain = wdata_q at all times. Both addresses hold their last value when idle.
- ACCESS, write (owner D, we_q = 1):
  - Exactly one cycle, mem_wr = 1, then DONE.
  - mem_wr is 0 in every other state and cycle.
- ACCESS, read:
  - Lasts MEM_LAT cycles, counted down by cnt.
  - At the end of the last ACCESS cycle, capture mem_dataout into the owner's rdata register; state goes to DONE.
- DONE: lasts one cycle.
  - Owner's done = 1; the other requester's done = 0.
  - Next state is IDLE; no request is accepted in DONE.
- Timing, with the gnt cycle as cycle 0:
  - Read: done in cycle MEM_LAT+1; earliest next gnt in cycle MEM_LAT+2.
  - Write: mem_wr in cycle 1, done in cycle 2.
- Requester rules:
  - Hold req, addr and wdata until gnt. After gnt they may change freely.
  - A req still high in the cycle after done is treated as a new request.
- The non-owner's rdata is never modified.
- Simultaneous events: a new req arriving during ACCESS or DONE waits. Fairness applies on the next IDLE, so with both held high grants alternate D, IF, D, IF...

Decomposition:
- Package mem_arb_pkg: state enum {IDLE, ACCESS, DONE}; requester enum {REQ_IF, REQ_D}; localparam helper for the counter width, $clog2(MEM_LAT+1).
- Single module; no sub-module needed. The 2-way round-robin is a few lines of logic.

Test Plan:
- RESET pulse, no requests -> all outputs 0, busy 0, mem_wr never 1.
- MEM_LAT=2, if_req with if_addr=0x40, memory returns 0xDEADBEEF_CAFEF00D -> if_gnt cycle 0; mem_raddress=0x40 from cycle 1; if_done cycle 3; if_rdata=0xDEADBEEF_CAFEF00D held afterwards; d_rdata stays 0.
- d_req, d_we=1, d_addr=0x100, d_wdata=0x1234 -> d_gnt cycle 0; mem_wr=1 only in cycle 1 with mem_waddress=0x100 and mem_datain=0x1234; d_done cycle 2.
- After reset, if_req and d_req both held high (reads) -> grant order D, IF, D, IF with gnts spaced MEM_LAT+2 cycles; each done goes only to its owner.
- RESET asserted in cycle 1 of a fetch read -> state IDLE immediately, no if_done ever, if_rdata=0; a following fetch of 0x80 completes normally in cycle 3.
- if_req held high through if_done -> no gnt in the DONE cycle; new if_gnt in cycle MEM_LAT+2, and the second access uses the new if_addr.
